uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Serial RS-232 receive controller for the UART peripheral on the RISC-V single-cycle core.
- Contains a 2-FF input synchronizer, an internal bit-period timer with full-bit and half-bit compares, and the frame state machine that sequences the timer.
- Deserializes 8N1 frames (parity optional), LSB first.
- Presents each received byte to the core's memory-mapped UART register through a ready/ack handshake, with framing, parity and overrun flags.

Parameters:
- BIT_COUNTS, 11: clock cycles per bit period (clk_freq / baud). Must be ≥ 4.
- DATA_BITS, 8: data bits per frame (5..8).
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity. Ignored when PARITY_EN = 0.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset (rst = 0 resets).
- rx, input, 1: asynchronous serial line, idles high.
- rx_ack, input, 1: consumer pulse; clears rx_ready and overrun_err.
- rx_data, output, DATA_BITS: last received data word.
- rx_ready, output, 1: sticky; high when an unread frame is held.
- frame_err, output, 1: stop bit of the last frame sampled low.
- parity_err, output, 1: parity mismatch on the last frame; always 0 when PARITY_EN = 0.
- overrun_err, output, 1: sticky; a frame completed while rx_ready was still high.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; timer count = 0; bit index = 0; shift register = 0.
  - Both synchronizer flops = 1.
  - rx_data = 0; rx_ready, frame_err, parity_err, overrun_err and busy all = 0.
- Synchronizer: rx passes through two flops to give rx_s. All decisions use rx_s only.
- Timer:
  - count is held at 0 in IDLE.
  - In every other state it increments each cycle.
  - HALF = (BIT_COUNTS-1)/2 (integer division). FULL = BIT_COUNTS-1.
  - Width is clog2(BIT_COUNTS).
- States:
  - IDLE: when rx_s = 0, go to START. count stays 0 on that edge.
  - START:
    - At count == HALF with rx_s = 0: clear count, set bit index = 0, go to DATA.
    - At count == HALF with rx_s = 1: false start; go to IDLE with no flags changed.
  - DATA:
    - At count == FULL: shift rx_s into the shift register MSB; the register shifts right so the first bit lands in the LSB. Wrap count to 0 and increment bit index.
    - After the DATA_BITS-th sample, go to PARITY if PARITY_EN = 1, else go to STOP.
  - PARITY: at count == FULL, latch the parity result, wrap count, go to STOP.
    - Error when XOR(data bits, received parity bit) != PARITY_ODD.
  - STOP: at count == FULL, complete the frame (see below).
    - rx_s = 1: go to IDLE.
    - rx_s = 0: go to BREAK.
  - BREAK: hold until rx_s = 1, then go to IDLE. No start detection happens while in BREAK.
- Frame completion (registered, visible the cycle after the stop sample):
  - rx_data = shift register; frame_err = !rx_s; parity_err = latched result; rx_ready = 1.
  - overrun_err = 1 if rx_ready was already 1 and rx_ack = 0 in the completion cycle. The old data is overwritten.
- rx_ack:
  - Clears rx_ready and overrun_err on the next edge.
  - rx_ack has no effect on rx_data, frame_err or parity_err.
  - If rx_ack and completion occur in the same cycle, completion wins: rx_ready = 1 and overrun is not set.
- Reset mid-frame: abort immediately to the reset values. A partial frame never sets rx_ready.

Test Plan:
1. BIT_COUNTS = 16, no parity; rx low before edge 0, then bits of 0xA5 LSB first, then stop = 1.
   - Bit k is sampled at edge 26+16k.
   - After edge 154: rx_data = 0xA5, rx_ready = 1, frame_err = 0, busy = 0.
2. Glitch: rx low for 5 cycles, then high (BIT_COUNTS = 16).
   - START returns to IDLE at the HALF sample; rx_ready stays 0; no flags change.
3. Stop bit held low, then rx held low for 3 more bit times.
   - frame_err = 1 with rx_ready = 1.
   - busy stays 1 (BREAK state) until rx returns high; no second frame is received.
4. Two back-to-back frames 0x3C then 0xC3 with no rx_ack.
   - After the second frame: rx_data = 0xC3, overrun_err = 1.
   - rx_ack pulse then clears rx_ready and overrun_err.
5. PARITY_EN = 1, PARITY_ODD = 0; send 0x07 with parity bit 0 (wrong; even parity requires 1).
   - parity_err = 1.
   - Resend with parity bit 1: parity_err = 0.
6. rst driven low during DATA bit 3, then released.
   - All outputs = 0 and state = IDLE.
   - Next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-FF synchronizer, bit-period timer and frame FSM.
// Presents each received word through a sticky ready/ack handshake with error flags.
module uart_rx_ctrl #(
    parameter int unsigned BIT_COUNTS = 11,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(BIT_COUNTS);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((BIT_COUNTS - 1) / 2);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(BIT_COUNTS - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_ready;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_rx_s;
    logic w_par_calc;

    assign w_rx_s     = r_sync2;
    // Even parity: XOR of data and parity bit must be 0; odd: must be 1.
    assign w_par_calc = ((^r_shift) ^ w_rx_s) != 1'(PARITY_ODD);

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_data       <= '0;
            r_ready      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Completion in StStop below overrides this when both happen together.
            if (rx_ack) begin
                r_ready   <= 1'b0;
                r_overrun <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (r_cnt == HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_bit_idx <= '0;
                            r_state   <= StData;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (r_cnt == FULL) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StParity: begin
                    if (r_cnt == FULL) begin
                        r_cnt     <= '0;
                        r_par_err <= w_par_calc;
                        r_state   <= StStop;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (r_cnt == FULL) begin
                        r_cnt        <= '0;
                        r_data       <= r_shift;
                        r_frame_err  <= !w_rx_s;
                        r_parity_err <= r_par_err;
                        r_ready      <= 1'b1;
                        if (r_ready && !rx_ack) begin
                            r_overrun <= 1'b1;
                        end
                        r_state <= w_rx_s ? StIdle : StBreak;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StBreak: begin
                    if (w_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign rx_data     = r_data;
    assign rx_ready    = r_ready;
    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx_ctrl;

    localparam int unsigned BC = 16;

    logic       clk;
    logic       rst;
    logic       rx, rx_ack;
    logic       rx_p, rx_ack_p;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_ready, frame_err, parity_err, overrun_err, busy;
    logic       rx_ready_p, frame_err_p, parity_err_p, overrun_err_p, busy_p;

    int n_checks;
    int n_fail;

    // Frame-level model of the no-parity receiver.
    logic [7:0] m_data;
    logic       m_ready, m_ferr, m_ovr;

    // Snapshots taken inside the frame driver around the completion edge.
    logic snap_ready_153, snap_ready_154, snap_busy_154;

    uart_rx_ctrl #(
        .BIT_COUNTS (BC),
        .DATA_BITS  (8),
        .PARITY_EN  (0),
        .PARITY_ODD (0)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    uart_rx_ctrl #(
        .BIT_COUNTS (BC),
        .DATA_BITS  (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) u_dut_par (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx_p),
        .rx_ack      (rx_ack_p),
        .rx_data     (rx_data_p),
        .rx_ready    (rx_ready_p),
        .frame_err   (frame_err_p),
        .parity_err  (parity_err_p),
        .overrun_err (overrun_err_p),
        .busy        (busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives start, data LSB first, optional parity, stop; each bit lasts BC cycles.
    // Returns early (line left as is) when the cycle index reaches abort_at.
    task automatic send_frame(input bit on_par, input logic [7:0] d, input logic p,
                              input logic stop, input int abort_at);
        logic [10:0] bits;
        int          nb;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (on_par) begin
            bits[9]  = p;
            bits[10] = stop;
            nb       = 11;
        end else begin
            bits[9] = stop;
            nb      = 10;
        end
        for (int c = 0; c < nb * int'(BC); c++) begin
            @(negedge clk);
            if (c == abort_at) return;
            if (c == 154) snap_ready_153 = rx_ready;
            if (c == 155) begin
                snap_ready_154 = rx_ready;
                snap_busy_154  = busy;
            end
            if (on_par) rx_p = bits[c / int'(BC)];
            else        rx   = bits[c / int'(BC)];
        end
        @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
        m_data  = d;
        m_ferr  = !stop;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack  = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_data"}, 32'(rx_data), 32'(m_data));
        check_eq({tag, "_ready"}, 32'(rx_ready), 32'(m_ready));
        check_eq({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        check_eq({tag, "_ovr"}, 32'(overrun_err), 32'(m_ovr));
        check_eq({tag, "_perr"}, 32'(parity_err), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       p;
        n_checks = 0;
        n_fail   = 0;
        rx = 1'b1; rx_ack = 1'b0; rx_p = 1'b1; rx_ack_p = 1'b0;
        m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        rst = 1'b0;
        idle(3);
        check_model("reset");
        check_eq("reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        idle(3);

        // Directed: 0xA5 with exact completion timing.
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
        model_frame(8'hA5, 1'b1);
        check_eq("t1_ready_e153", 32'(snap_ready_153), 32'd0);
        check_eq("t1_ready_e154", 32'(snap_ready_154), 32'd1);
        check_eq("t1_busy_e154", 32'(snap_busy_154), 32'd0);
        check_model("t1");

        // Glitch shorter than half a bit.
        pulse_ack();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(3);
        check_eq("t2_busy_mid", 32'(busy), 32'd1);
        idle(30);
        check_eq("t2_busy_end", 32'(busy), 32'd0);
        check_model("t2");

        // Low stop bit followed by a held break.
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, -1);
        model_frame(8'h81, 1'b0);
        check_model("t3");
        idle(3 * BC);
        check_eq("t3_busy_break", 32'(busy), 32'd1);
        check_model("t3_hold");
        rx = 1'b1;
        idle(4);
        check_eq("t3_busy_release", 32'(busy), 32'd0);

        // Back-to-back frames without ack.
        pulse_ack();
        idle(2);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, -1);
        model_frame(8'h3C, 1'b1);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, -1);
        model_frame(8'hC3, 1'b1);
        check_model("t4");
        pulse_ack();
        check_model("t4_ack");

        // Parity variant: even parity, 0x07 needs parity bit 1.
        for (int k = 0; k < 2; k++) begin
            p = 1'(k);
            send_frame(1'b1, 8'h07, p, 1'b1, -1);
            check_eq("t5_data", 32'(rx_data_p), 32'h07);
            check_eq("t5_ready", 32'(rx_ready_p), 32'd1);
            check_eq("t5_perr", 32'(parity_err_p), 32'(((^8'h07) ^ p) != 1'b0));
            check_eq("t5_ferr", 32'(frame_err_p), 32'd0);
            @(negedge clk); rx_ack_p = 1'b1;
            @(negedge clk); rx_ack_p = 1'b0;
            idle(2);
        end

        // Reset during data bit 3.
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 70);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_model("t6_rst");
        check_eq("t6_busy", 32'(busy), 32'd0);
        idle(2);
        rst = 1'b1;
        idle(3);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, -1);
        model_frame(8'h5A, 1'b1);
        check_model("t6_next");

        // Random frames with random stop errors and acks.
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) pulse_ack();
            send_frame(1'b0, d, 1'b0, stop, -1);
            model_frame(d, stop);
            check_model("rnd");
            check_eq("rnd_busy", 32'(busy), 32'(!stop));
            if (!stop) begin
                idle($urandom_range(20, 60));
                rx = 1'b1;
            end
            idle($urandom_range(3, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
